// File: rtl/zelda_gfx_pkg.sv
// rtl/zelda_gfx_pkg.sv - shared types, palettes and screen constants for the Zelda pixel compositor
package zelda_gfx_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        SEL_DOWN   = 3'd0,
        SEL_UP     = 3'd1,
        SEL_LEFT   = 3'd2,
        SEL_RIGHT1 = 3'd3,
        SEL_RIGHT2 = 3'd4
    } spr_sel_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Packed palettes: element [0] is the rightmost literal.
    localparam logic [15:0][11:0] BG_PAL = {
        12'hFFF, 12'hEED, 12'hDDB, 12'hCC9, 12'hBA7, 12'hA85, 12'h963, 12'h841,
        12'h6D7, 12'h5B3, 12'h48A, 12'h3C5, 12'h2A4, 12'h246, 12'h124, 12'h000
    };

    localparam logic [15:0][11:0] SPR_PAL = {
        12'h111, 12'hDDD, 12'h4A4, 12'h262, 12'hFDB, 12'hE94, 12'hA52, 12'h430,
        12'h888, 12'h0FF, 12'hFC9, 12'hFF0, 12'h00F, 12'h0F0, 12'hF00, 12'h000
    };

    localparam logic [11:0] BORDER_RGB = 12'h303;
    localparam logic [11:0] HITBOX_RGB = 12'hF0F;

endpackage

// File: rtl/zelda_pixel_compositor_if.sv
// rtl/zelda_pixel_compositor_if.sv - background/sprite ROM address and data bus
interface zelda_pixel_compositor_if;
    import zelda_gfx_pkg::*;

    logic [17:0] bg_addr;
    logic [3:0]  bg_q;
    logic [9:0]  spr_addr;
    spr_sel_t    spr_sel;
    logic [3:0]  spr_q;

    modport master (output bg_addr, output spr_addr, output spr_sel, input bg_q, input spr_q);
    modport slave  (input bg_addr, input spr_addr, input spr_sel, output bg_q, output spr_q);
endinterface

// File: rtl/zelda_anim_ctrl.sv
// rtl/zelda_anim_ctrl.sv - per-frame sprite state latch, walk animation and sprite ROM select decode
module zelda_anim_ctrl
    import zelda_gfx_pkg::*;
#(
    parameter int ANIM_FRAMES = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic [9:0] link_x,
    input  logic [9:0] link_y,
    input  logic [1:0] link_dir,
    input  logic       link_moving,
    output logic [9:0] lx,
    output logic [9:0] ly,
    output spr_sel_t   spr_sel
);
    localparam int CW = $clog2(ANIM_FRAMES);

    dir_t          dir;
    logic [CW-1:0] anim_cnt;
    logic          walk_phase;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lx         <= '0;
            ly         <= '0;
            dir        <= DIR_DOWN;
            anim_cnt   <= '0;
            walk_phase <= 1'b0;
        end else if (frame_start) begin
            lx  <= link_x;
            ly  <= link_y;
            dir <= dir_t'(link_dir);
            if (!link_moving) begin
                anim_cnt   <= '0;
                walk_phase <= 1'b0;
            end else if (anim_cnt == CW'(ANIM_FRAMES - 1)) begin
                anim_cnt   <= '0;
                walk_phase <= ~walk_phase;
            end else begin
                anim_cnt <= anim_cnt + 1'b1;
            end
        end
    end

    // Only the right-facing sprite has two walk frames in ROM.
    always_comb begin
        spr_sel = SEL_DOWN;
        case (dir)
            DIR_DOWN:  spr_sel = SEL_DOWN;
            DIR_UP:    spr_sel = SEL_UP;
            DIR_LEFT:  spr_sel = SEL_LEFT;
            DIR_RIGHT: spr_sel = walk_phase ? SEL_RIGHT2 : SEL_RIGHT1;
            default:   spr_sel = SEL_DOWN;
        endcase
    end
endmodule

// File: rtl/zelda_pixel_compositor.sv
// rtl/zelda_pixel_compositor.sv - 3-stage bg/sprite compositor; DEBUG_HITBOX_EN adds a magenta sprite box outline
module zelda_pixel_compositor
    import zelda_gfx_pkg::*;
#(
    parameter int         BG_W        = 500,
    parameter int         BG_H        = 480,
    parameter int         SPR_W       = 32,
    parameter int         ANIM_FRAMES = 8,
    parameter logic [3:0] TRANSP_IDX  = 4'd0
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [9:0]                       draw_x,
    input  logic [9:0]                       draw_y,
    input  logic                             blank_n,
    input  logic                             frame_start,
    input  logic [9:0]                       link_x,
    input  logic [9:0]                       link_y,
    input  logic [1:0]                       link_dir,
    input  logic                             link_moving,
    zelda_pixel_compositor_if.master         rom,
    output logic [3:0]                       red,
    output logic [3:0]                       green,
    output logic [3:0]                       blue
);
    localparam int SB = $clog2(SPR_W);

    logic [9:0]  lx, ly;
    spr_sel_t    sel_next;

    zelda_anim_ctrl #(.ANIM_FRAMES(ANIM_FRAMES)) u_anim (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .link_x      (link_x),
        .link_y      (link_y),
        .link_dir    (link_dir),
        .link_moving (link_moving),
        .lx          (lx),
        .ly          (ly),
        .spr_sel     (sel_next)
    );

    logic [10:0] dx, dy;
    logic [17:0] yy, bg_addr_c;
    logic        in_spr_c, bg_valid_c;
    logic        in_spr1, bg_valid1, blank1;
    logic        in_spr2, bg_valid2, blank2;
    logic [11:0] rgb_c, rgb;

    // y*500 as shifts; a negative sprite offset wraps to a large unsigned value and falls outside the box.
    always_comb begin
        dx         = {1'b0, draw_x} - {1'b0, lx};
        dy         = {1'b0, draw_y} - {1'b0, ly};
        in_spr_c   = (dx < 11'(SPR_W)) && (dy < 11'(SPR_W));
        bg_valid_c = (draw_x < 10'(BG_W)) && (draw_y < 10'(BG_H));
        yy         = 18'(draw_y);
        bg_addr_c  = bg_valid_c ? ((yy << 9) - (yy << 3) - (yy << 2) + 18'(draw_x)) : 18'd0;
    end

`ifdef DEBUG_HITBOX_EN
    logic edge_c, edge1, edge2;
    always_comb begin
        edge_c = in_spr_c && ((dx[SB-1:0] == '0) || (dx[SB-1:0] == '1) ||
                              (dy[SB-1:0] == '0) || (dy[SB-1:0] == '1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            edge1 <= 1'b0;
            edge2 <= 1'b0;
        end else begin
            edge1 <= edge_c;
            edge2 <= edge1;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rom.bg_addr  <= '0;
            rom.spr_addr <= '0;
            rom.spr_sel  <= SEL_DOWN;
            in_spr1      <= 1'b0;
            bg_valid1    <= 1'b0;
            blank1       <= 1'b0;
            in_spr2      <= 1'b0;
            bg_valid2    <= 1'b0;
            blank2       <= 1'b0;
            rgb          <= '0;
        end else begin
            rom.bg_addr  <= bg_addr_c;
            rom.spr_addr <= {dy[SB-1:0], dx[SB-1:0]};
            rom.spr_sel  <= sel_next;
            in_spr1      <= in_spr_c;
            bg_valid1    <= bg_valid_c;
            blank1       <= blank_n;
            in_spr2      <= in_spr1;
            bg_valid2    <= bg_valid1;
            blank2       <= blank1;
            rgb          <= rgb_c;
        end
    end

    always_comb begin
        rgb_c = BORDER_RGB;
        if (!blank2)
            rgb_c = 12'h000;
`ifdef DEBUG_HITBOX_EN
        else if (edge2)
            rgb_c = HITBOX_RGB;
`endif
        else if (in_spr2 && (rom.spr_q != TRANSP_IDX))
            rgb_c = SPR_PAL[rom.spr_q];
        else if (bg_valid2)
            rgb_c = BG_PAL[rom.bg_q];
    end

    assign red   = rgb[11:8];
    assign green = rgb[7:4];
    assign blue  = rgb[3:0];
endmodule

// File: tb/tb_zelda_pixel_compositor.sv
// tb/tb_zelda_pixel_compositor.sv - directed self-checking bench for zelda_pixel_compositor
module tb_zelda_pixel_compositor;
    logic       clock = 1'b0;
    logic       reset_n;
    logic [9:0] draw_x, draw_y, link_x, link_y;
    logic       blank_n, frame_start, link_moving;
    logic [1:0] link_dir;
    logic [3:0] red, green, blue;
    int         n_checks = 0;
    int         n_fail = 0;

    zelda_pixel_compositor_if rom_bus ();

    zelda_pixel_compositor dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .blank_n     (blank_n),
        .frame_start (frame_start),
        .link_x      (link_x),
        .link_y      (link_y),
        .link_dir    (link_dir),
        .link_moving (link_moving),
        .rom         (rom_bus),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    always #5 clock = ~clock;

    task automatic apply(input logic [9:0] x, input logic [9:0] y);
        @(negedge clock);
        draw_x = x;
        draw_y = y;
        repeat (3) @(negedge clock);
    endtask

    task automatic pulse_frame();
        @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [11:0] exp_rgb;
        reset_n = 1'b0; draw_x = 10'd0; draw_y = 10'd0; blank_n = 1'b1; frame_start = 1'b0;
        link_x = 10'd0; link_y = 10'd0; link_dir = 2'd0; link_moving = 1'b0;
        rom_bus.bg_q = 4'h3; rom_bus.spr_q = 4'h0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got %h want 000", {red, green, blue}); end
        n_checks++;
        if (rom_bus.bg_addr !== 18'd0 || rom_bus.spr_addr !== 10'd0) begin
            n_fail++; $display("FAIL reset_addr got %0d/%h want 0/0", rom_bus.bg_addr, rom_bus.spr_addr);
        end
        n_checks++;
        if (rom_bus.spr_sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", rom_bus.spr_sel); end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL latency_early got %h want 000", {red, green, blue}); end
        @(negedge clock);
`ifdef DEBUG_HITBOX_EN
        exp_rgb = 12'hF0F;
`else
        exp_rgb = 12'h2A4;
`endif
        n_checks++;
        if ({red, green, blue} !== exp_rgb) begin n_fail++; $display("FAIL first_pixel got %h want %h", {red, green, blue}, exp_rgb); end
        n_checks++;
        if (rom_bus.bg_addr !== 18'd0) begin n_fail++; $display("FAIL first_addr got %0d want 0", rom_bus.bg_addr); end
    endtask

    task automatic test_bg_bounds();
        rom_bus.bg_q = 4'h3; rom_bus.spr_q = 4'h0;
        apply(10'd499, 10'd479);
        n_checks++;
        if (rom_bus.bg_addr !== 18'd239999) begin n_fail++; $display("FAIL bg_last_addr got %0d want 239999", rom_bus.bg_addr); end
        n_checks++;
        if ({red, green, blue} !== 12'h2A4) begin n_fail++; $display("FAIL bg_last_rgb got %h want 2a4", {red, green, blue}); end
        apply(10'd500, 10'd479);
        n_checks++;
        if (rom_bus.bg_addr !== 18'd0) begin n_fail++; $display("FAIL bg_x500_addr got %0d want 0", rom_bus.bg_addr); end
        n_checks++;
        if ({red, green, blue} !== 12'h303) begin n_fail++; $display("FAIL bg_x500_rgb got %h want 303", {red, green, blue}); end
        apply(10'd499, 10'd480);
        n_checks++;
        if (rom_bus.bg_addr !== 18'd0 || {red, green, blue} !== 12'h303) begin
            n_fail++; $display("FAIL bg_y480 got %0d/%h want 0/303", rom_bus.bg_addr, {red, green, blue});
        end
        apply(10'd7, 10'd1);
        n_checks++;
        if (rom_bus.bg_addr !== 18'd507) begin n_fail++; $display("FAIL bg_row1_addr got %0d want 507", rom_bus.bg_addr); end
        blank_n = 1'b0;
        apply(10'd499, 10'd479);
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL blank_rgb got %h want 000", {red, green, blue}); end
        blank_n = 1'b1;
    endtask

    task automatic test_sprite();
        logic [11:0] exp_edge;
`ifdef DEBUG_HITBOX_EN
        exp_edge = 12'hF0F;
`else
        exp_edge = 12'hFC9;
`endif
        link_x = 10'd100; link_y = 10'd50; link_dir = 2'd0; link_moving = 1'b0;
        pulse_frame();
        rom_bus.bg_q = 4'h7; rom_bus.spr_q = 4'h5;
        apply(10'd131, 10'd81);
        n_checks++;
        if (rom_bus.spr_addr !== 10'h3FF) begin n_fail++; $display("FAIL spr_corner_addr got %h want 3ff", rom_bus.spr_addr); end
        n_checks++;
        if ({red, green, blue} !== exp_edge) begin n_fail++; $display("FAIL spr_corner_rgb got %h want %h", {red, green, blue}, exp_edge); end
        apply(10'd110, 10'd60);
        n_checks++;
        if (rom_bus.spr_addr !== 10'h14A) begin n_fail++; $display("FAIL spr_mid_addr got %h want 14a", rom_bus.spr_addr); end
        n_checks++;
        if ({red, green, blue} !== 12'hFC9) begin n_fail++; $display("FAIL spr_mid_rgb got %h want fc9", {red, green, blue}); end
        rom_bus.spr_q = 4'h0;
        apply(10'd111, 10'd61);
        n_checks++;
        if ({red, green, blue} !== 12'h6D7) begin n_fail++; $display("FAIL spr_transp got %h want 6d7", {red, green, blue}); end
        rom_bus.spr_q = 4'h5;
        apply(10'd100, 10'd50);
        n_checks++;
        if ({red, green, blue} !== exp_edge) begin n_fail++; $display("FAIL spr_origin got %h want %h", {red, green, blue}, exp_edge); end
        apply(10'd99, 10'd60);
        n_checks++;
        if ({red, green, blue} !== 12'h6D7) begin n_fail++; $display("FAIL spr_left_out got %h want 6d7", {red, green, blue}); end
        apply(10'd132, 10'd60);
        n_checks++;
        if ({red, green, blue} !== 12'h6D7) begin n_fail++; $display("FAIL spr_right_out got %h want 6d7", {red, green, blue}); end
    endtask

    task automatic test_frame_latch();
        link_x = 10'd200;
        apply(10'd131, 10'd81);
        n_checks++;
        if (rom_bus.spr_addr !== 10'h3FF) begin n_fail++; $display("FAIL latch_hold got %h want 3ff", rom_bus.spr_addr); end
        @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        n_checks++;
        if (rom_bus.spr_addr !== 10'h3FF) begin n_fail++; $display("FAIL latch_coincident got %h want 3ff", rom_bus.spr_addr); end
        @(negedge clock);
        n_checks++;
        if (rom_bus.spr_addr !== 10'h3FB) begin n_fail++; $display("FAIL latch_new got %h want 3fb", rom_bus.spr_addr); end
        repeat (2) @(negedge clock);
        n_checks++;
        if ({red, green, blue} !== 12'h6D7) begin n_fail++; $display("FAIL latch_rgb got %h want 6d7", {red, green, blue}); end
    endtask

    task automatic test_anim();
        link_dir = 2'd1; link_moving = 1'b1;
        repeat (7) pulse_frame();
        n_checks++;
        if (rom_bus.spr_sel !== 3'd3) begin n_fail++; $display("FAIL anim_7 got %0d want 3", rom_bus.spr_sel); end
        pulse_frame();
        n_checks++;
        if (rom_bus.spr_sel !== 3'd4) begin n_fail++; $display("FAIL anim_8 got %0d want 4", rom_bus.spr_sel); end
        link_moving = 1'b0;
        pulse_frame();
        n_checks++;
        if (rom_bus.spr_sel !== 3'd3) begin n_fail++; $display("FAIL anim_stop got %0d want 3", rom_bus.spr_sel); end
        link_dir = 2'd2;
        pulse_frame();
        n_checks++;
        if (rom_bus.spr_sel !== 3'd1) begin n_fail++; $display("FAIL dir_up got %0d want 1", rom_bus.spr_sel); end
        link_dir = 2'd3;
        pulse_frame();
        n_checks++;
        if (rom_bus.spr_sel !== 3'd2) begin n_fail++; $display("FAIL dir_left got %0d want 2", rom_bus.spr_sel); end
        link_dir = 2'd0;
        pulse_frame();
        n_checks++;
        if (rom_bus.spr_sel !== 3'd0) begin n_fail++; $display("FAIL dir_down got %0d want 0", rom_bus.spr_sel); end
    endtask

    task automatic test_reset_midline();
        rom_bus.bg_q = 4'h7; rom_bus.spr_q = 4'h5;
        link_dir = 2'd1;
        pulse_frame();
        apply(10'd10, 10'd10);
        n_checks++;
        if ({red, green, blue} !== 12'h6D7) begin n_fail++; $display("FAIL pre_reset got %h want 6d7", {red, green, blue}); end
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL async_reset_rgb got %h want 000", {red, green, blue}); end
        n_checks++;
        if (rom_bus.spr_sel !== 3'd0 || rom_bus.bg_addr !== 18'd0) begin
            n_fail++; $display("FAIL async_reset_bus got %0d/%0d want 0/0", rom_bus.spr_sel, rom_bus.bg_addr);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL post_reset_black got %h want 000", {red, green, blue}); end
        @(negedge clock);
        n_checks++;
        if ({red, green, blue} !== 12'hFC9) begin n_fail++; $display("FAIL post_reset_pixel got %h want fc9", {red, green, blue}); end
    endtask

    initial begin
        test_reset();
        test_bg_bounds();
        test_sprite();
        test_frame_latch();
        test_anim();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
